// File: rtl/uart_rxd_deserializer.sv
// uart_rxd_deserializer
//   8N1 UART receive front end. Oversamples the asynchronous serial line,
//   rebuilds each byte and hands it to the RxD FIFO through a one-entry
//   holding register with a valid/ready style handshake.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high reset
//   rx_i         asynchronous serial input, idles high
//   RxD_din      received byte, valid while RxD_wr = 1
//   RxD_wr       holding register holds a byte
//   RxD_ready    consumer accepts; transfer when RxD_wr & RxD_ready
//   frame_err_o  1-cycle pulse: stop bit sampled low
//   overrun_o    1-cycle pulse: new byte dropped, holding register full
//   busy_o       1 while the receiver is not idle
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | line idle, waiting for a low level on the synchronized input
// START | half a bit into the start bit, confirming it is still low
// DATA  | sampling the 8 data bits at bit centres, LSB first
// STOP  | sampling the stop bit; high completes the byte
// BREAK | stop bit was low; wait for the line to return high
module uart_rxd_deserializer #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_i,
  output logic [7:0] RxD_din,
  output logic       RxD_wr,
  input  logic       RxD_ready,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       busy_o
);

  localparam int CNTw = $clog2(CLKS_PER_BIT);
  localparam logic [CNTw-1:0] FULL_LAST = CNTw'(CLKS_PER_BIT - 1);
  localparam logic [CNTw-1:0] HALF_LAST = CNTw'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  state_t          state;
  logic            rx_meta;
  logic            rx_s;
  logic [CNTw-1:0] timer;
  logic [2:0]      idx;
  logic [7:0]      shreg;
  logic [7:0]      hold_data;
  logic            hold_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta     <= 1'b1;
      rx_s        <= 1'b1;
      state       <= IDLE;
      timer       <= '0;
      idx         <= '0;
      shreg       <= '0;
      hold_data   <= '0;
      hold_valid  <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      rx_meta     <= rx_i;
      rx_s        <= rx_meta;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;

      // Consumer handshake; a byte completing in this same cycle overrides
      // the clear below, so a full register can be refilled without a gap.
      if (hold_valid && RxD_ready) begin
        hold_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          timer <= '0;
          if (!rx_s) begin
            state <= START;
          end
        end

        START: begin
          if (timer == HALF_LAST) begin
            timer <= '0;
            if (!rx_s) begin
              state <= DATA;
              idx   <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            timer <= timer + CNTw'(1);
          end
        end

        DATA: begin
          if (timer == FULL_LAST) begin
            timer <= '0;
            shreg <= {rx_s, shreg[7:1]};
            idx   <= idx + 3'd1;
            if (idx == 3'd7) begin
              state <= STOP;
            end
          end else begin
            timer <= timer + CNTw'(1);
          end
        end

        STOP: begin
          if (timer == FULL_LAST) begin
            timer <= '0;
            if (rx_s) begin
              // Return to IDLE right at mid stop bit so a back-to-back
              // start edge is not missed.
              state <= IDLE;
              if (!hold_valid || RxD_ready) begin
                hold_data  <= shreg;
                hold_valid <= 1'b1;
              end else begin
                overrun_o <= 1'b1;
              end
            end else begin
              frame_err_o <= 1'b1;
              state       <= BREAK;
            end
          end else begin
            timer <= timer + CNTw'(1);
          end
        end

        BREAK: begin
          // A held-low line reports once; no restart until it goes high.
          timer <= '0;
          if (rx_s) begin
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
          timer <= '0;
        end
      endcase
    end
  end

  assign RxD_wr  = hold_valid;
  assign RxD_din = hold_data;
  assign busy_o  = (state != IDLE);

endmodule

// File: tb/tb_uart_rxd_deserializer.sv
// Bench for uart_rxd_deserializer with CLKS_PER_BIT = 16. Expected bytes
// go into a scoreboard queue as frames are sent and are compared whenever
// the DUT completes a transfer; error pulses are counted and checked.
module tb_uart_rxd_deserializer;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_i = 1'b1;
  logic [7:0] RxD_din;
  logic       RxD_wr;
  logic       RxD_ready = 1'b1;
  logic       frame_err_o;
  logic       overrun_o;
  logic       busy_o;

  int vectors = 0;
  int miscompares = 0;
  int n_ferr = 0;
  int n_ovr = 0;
  logic [7:0] exp_q[$];
  logic       prev_hold = 1'b0;
  logic [7:0] prev_din = 8'h00;

  uart_rxd_deserializer #(.CLKS_PER_BIT(CPB)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_i        (rx_i),
    .RxD_din     (RxD_din),
    .RxD_wr      (RxD_wr),
    .RxD_ready   (RxD_ready),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Transfer monitor and pulse counter, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) chk("hold_stable", {23'd0, RxD_wr, RxD_din}, {23'd0, 1'b1, prev_din});
      if (RxD_wr && RxD_ready) begin
        chk("sb_expected", (exp_q.size() != 0) ? 32'd1 : 32'd0, 32'd1);
        if (exp_q.size() != 0) chk("byte", {24'd0, RxD_din}, {24'd0, exp_q.pop_front()});
      end
      if (frame_err_o && overrun_o) chk("err_excl", 32'd1, 32'd0);
      if (frame_err_o) n_ferr++;
      if (overrun_o) n_ovr++;
      prev_hold = RxD_wr && !RxD_ready;
      prev_din  = RxD_din;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One 10-bit frame, one iteration per clock, driven 1 ns after the edge.
  // The stop bit is sampled at the 155th edge after the start bit is driven,
  // so the byte is visible at iteration 155.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            input int ready_at, input int reset_at, input int lat);
    for (int c = 0; c < 10 * CPB; c++) begin
      int k;
      k = c / CPB;
      if (k == 0) rx_i = 1'b0;
      else if (k <= 8) rx_i = b[k-1];
      else rx_i = stop_bit;
      if (c == ready_at) RxD_ready = 1'b1;
      if (c == reset_at) reset = 1'b1;
      if (reset_at >= 0 && c == reset_at + 1) begin
        reset = 1'b0;
        chk("rst_mid_outputs", {20'd0, RxD_wr, RxD_din, frame_err_o, overrun_o, busy_o}, 32'd0);
      end
      if (lat == 2 && c == 154) chk("lat_pre", {31'd0, RxD_wr}, 32'd0);
      if (lat >= 1 && c == 155) chk("lat_byte", {23'd0, RxD_wr, RxD_din}, {23'd0, 1'b1, b});
      @(posedge clk);
      #1;
    end
    rx_i = 1'b1;
  endtask

  initial begin
    int f0, o0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {20'd0, RxD_wr, RxD_din, frame_err_o, overrun_o, busy_o}, 32'd0);
    reset = 1'b0;
    idle(5);

    // 1: back-to-back frames
    f0 = n_ferr; o0 = n_ovr;
    exp_q.push_back(8'h41);
    send_frame(8'h41, 1'b1, -1, -1, 2);
    exp_q.push_back(8'h42);
    send_frame(8'h42, 1'b1, -1, -1, 1);
    idle(20);
    chk("t1_drain", exp_q.size(), 32'd0);
    chk("t1_errs", n_ferr - f0 + n_ovr - o0, 32'd0);

    // 2: short glitch rejected
    rx_i = 1'b0;
    idle(4);
    rx_i = 1'b1;
    idle(2);
    chk("t2_busy_glitch", {31'd0, busy_o}, 32'd1);
    idle(20);
    chk("t2_busy_back", {31'd0, busy_o}, 32'd0);
    chk("t2_no_byte", {31'd0, RxD_wr}, 32'd0);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, -1, -1, 1);
    idle(20);
    chk("t2_drain", exp_q.size(), 32'd0);

    // 3: framing error then long break
    f0 = n_ferr; o0 = n_ovr;
    send_frame(8'h55, 1'b0, -1, -1, 0);
    rx_i = 1'b0;
    idle(40 * CPB);
    chk("t3_busy_break", {31'd0, busy_o}, 32'd1);
    chk("t3_no_byte", {31'd0, RxD_wr}, 32'd0);
    rx_i = 1'b1;
    idle(20);
    chk("t3_busy_idle", {31'd0, busy_o}, 32'd0);
    exp_q.push_back(8'h0A);
    send_frame(8'h0A, 1'b1, -1, -1, 1);
    idle(20);
    chk("t3_ferr_count", n_ferr - f0, 32'd1);
    chk("t3_ovr_count", n_ovr - o0, 32'd0);
    chk("t3_drain", exp_q.size(), 32'd0);

    // 4: overrun while consumer stalls
    f0 = n_ferr; o0 = n_ovr;
    RxD_ready = 1'b0;
    exp_q.push_back(8'h31);
    send_frame(8'h31, 1'b1, -1, -1, 0);
    idle(10);
    chk("t4_held", {23'd0, RxD_wr, RxD_din}, {23'd0, 1'b1, 8'h31});
    send_frame(8'h32, 1'b1, -1, -1, 0);
    idle(10);
    chk("t4_still_held", {23'd0, RxD_wr, RxD_din}, {23'd0, 1'b1, 8'h31});
    chk("t4_ovr_count", n_ovr - o0, 32'd1);
    RxD_ready = 1'b1;
    idle(5);
    chk("t4_drain", exp_q.size(), 32'd0);
    chk("t4_empty", {31'd0, RxD_wr}, 32'd0);
    chk("t4_ferr_count", n_ferr - f0, 32'd0);

    // 5: ready rises in the stop-sample cycle
    f0 = n_ferr; o0 = n_ovr;
    RxD_ready = 1'b0;
    exp_q.push_back(8'h31);
    send_frame(8'h31, 1'b1, -1, -1, 0);
    idle(10);
    exp_q.push_back(8'h32);
    send_frame(8'h32, 1'b1, 154, -1, 1);
    idle(10);
    chk("t5_ovr_count", n_ovr - o0, 32'd0);
    chk("t5_drain", exp_q.size(), 32'd0);
    chk("t5_empty", {31'd0, RxD_wr}, 32'd0);

    // 6: reset during data bit 3; data bits 3..7 high keep the line quiet after
    send_frame(8'hF8, 1'b1, -1, 70, 0);
    idle(20);
    chk("t6_no_byte", {31'd0, RxD_wr}, 32'd0);
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, -1, -1, 1);
    idle(20);
    chk("t6_drain", exp_q.size(), 32'd0);
    chk("t6_ferr_total", n_ferr - f0, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
